// File: rtl/sigmoid_out_buffer.sv
// Output buffer for the fixed-latency sigmoid core: valid delay line, result FIFO and credit-gated issue.
// Optional stall statistics ports are enabled with `define SIGMOID_OBUF_STATS_EN.
module sigmoid_out_buffer #(
  parameter int DW    = 32,
  parameter int LAT   = 5,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] sig_result,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] occupancy
`ifdef SIGMOID_OBUF_STATS_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   credit_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(LAT+1);

  logic                rst_q;
  logic [LAT-1:0]      vld_sr_q, vld_sr_d;
  logic [IW-1:0]       inflight_q, inflight_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]       mem_q [DEPTH];
  logic                issue, capture, pop, empty, full;
  logic [PW-1:0]       occ_w;
  logic [31:0]         credit_used;

  always_comb begin
    empty       = (wr_ptr_q == rd_ptr_q);
    full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    occ_w       = wr_ptr_q - rd_ptr_q;
    credit_used = 32'(occ_w) + 32'(inflight_q);
    // Credit comes purely from registered state, so the core can never overrun the FIFO.
    in_ready    = !rst_q && (credit_used < 32'(DEPTH));
    issue       = in_valid & in_ready;
    capture     = vld_sr_q[LAT-1];
    out_valid   = !empty;
    pop         = out_valid & out_ready;
    out_data    = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    occupancy   = CW'(occ_w);
    vld_sr_d    = (vld_sr_q << 1) | LAT'(issue);
    inflight_d  = inflight_q + IW'(issue) - IW'(capture);
    wr_ptr_d    = wr_ptr_q + PW'(capture);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      vld_sr_q   <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      vld_sr_q   <= vld_sr_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && capture) mem_q[wr_ptr_q[AW-1:0]] <= sig_result;
  end

`ifdef SIGMOID_OBUF_STATS_EN
  logic [31:0] stall_q, stall_d, cstall_q, cstall_d;

  always_comb begin
    stall_d  = stall_q;
    cstall_d = cstall_q;
    if (out_valid && !out_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
    if (in_valid && !in_ready && cstall_q != 32'hFFFF_FFFF)  cstall_d = cstall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      cstall_q <= '0;
    end else begin
      stall_q  <= stall_d;
      cstall_q <= cstall_d;
    end
  end

  assign stall_cycles = stall_q;
  assign credit_stall = cstall_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(capture && full)) else $error("capture while full");
      assert (32'(inflight_q) <= LAT) else $error("inflight exceeds LAT");
      assert (credit_used <= 32'(DEPTH)) else $error("credit overcommitted");
    end
  end
`endif

endmodule
